// File: rtl/btn_conditioner.sv
// N-channel push-button front end: 2-flop sync, debounce, press/release
// strobes, long-press detection and auto-repeat while held.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG,
    output logic [N_BTN-1:0] BTN_REPEAT
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic              r_s1;
        logic              r_s2;
        logic              r_level;
        logic [DB_W-1:0]   r_db_cnt;
        logic              r_press;
        logic              r_release;
        logic              w_toggle;
        logic              w_rise;
        logic              w_fall;

        state_t            r_state;
        state_t            w_state_nxt;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic [REP_W-1:0]  r_rep_cnt;
        logic [REP_W-1:0]  w_rep_nxt;
        logic              r_long;
        logic              r_repeat;
        logic              w_long_d;
        logic              w_repeat_d;

        // The counter never stores DEBOUNCE_CYCLES; that step is the toggle.
        assign w_toggle = (r_s2 != r_level) && (r_db_cnt == DB_LAST);
        assign w_rise   = w_toggle && !r_level;
        assign w_fall   = w_toggle && r_level;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_level   <= 1'b0;
                r_db_cnt  <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_s1      <= BTN_IN[g];
                r_s2      <= r_s1;
                r_press   <= w_rise;
                r_release <= w_fall;
                if (r_s2 == r_level) begin
                    r_db_cnt <= '0;
                end else if (w_toggle) begin
                    r_db_cnt <= '0;
                    r_level  <= ~r_level;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_state    <= S_IDLE;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
                r_long     <= 1'b0;
                r_repeat   <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_hold_cnt <= w_hold_nxt;
                r_rep_cnt  <= w_rep_nxt;
                r_long     <= w_long_d;
                r_repeat   <= w_repeat_d;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold_cnt;
            w_rep_nxt   = r_rep_cnt;
            if (w_fall) begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
                w_rep_nxt   = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            w_state_nxt = S_HOLD;
                            w_hold_nxt  = HOLD_ONE;
                            w_rep_nxt   = '0;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == HOLD_MAX) begin
                            w_state_nxt = S_REPEAT;
                            w_rep_nxt   = '0;
                        end else begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (REPEAT_EN) begin
                            if (r_rep_cnt == REP_LAST) begin
                                w_rep_nxt = '0;
                            end else begin
                                w_rep_nxt = r_rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_hold_nxt  = '0;
                        w_rep_nxt   = '0;
                    end
                endcase
            end
        end

        // A release debounced on the same edge suppresses LONG/REPEAT.
        always_comb begin
            w_long_d   = 1'b0;
            w_repeat_d = 1'b0;
            if (!w_fall) begin
                w_long_d   = (r_state == S_HOLD)
                          && (r_hold_cnt == HOLD_MAX);
                w_repeat_d = REPEAT_EN
                          && (r_state == S_REPEAT)
                          && (r_rep_cnt == REP_LAST);
            end
        end

        assign BTN_LEVEL[g]   = r_level;
        assign BTN_PRESS[g]   = r_press;
        assign BTN_RELEASE[g] = r_release;
        assign BTN_LONG[g]    = r_long;
        assign BTN_REPEAT[g]  = r_repeat;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: default build plus a REPEAT_EN=0 build.
module tb_btn_conditioner;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] BTN_IN = '0;
    logic [4:0] BTN_IN2 = '0;

    logic [4:0] lvl0, pr0, rl0, lg0, rp0;
    logic [4:0] lvl1, pr1, rl1, lg1, rp1;
    logic [24:0] v0, v1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    btn_conditioner u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_IN      (BTN_IN),
        .BTN_LEVEL   (lvl0),
        .BTN_PRESS   (pr0),
        .BTN_RELEASE (rl0),
        .BTN_LONG    (lg0),
        .BTN_REPEAT  (rp0)
    );

    btn_conditioner #(.REPEAT_EN(1'b0)) u_dut_norep (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_IN      (BTN_IN2),
        .BTN_LEVEL   (lvl1),
        .BTN_PRESS   (pr1),
        .BTN_RELEASE (rl1),
        .BTN_LONG    (lg1),
        .BTN_REPEAT  (rp1)
    );

    assign v0 = {lvl0, pr0, rl0, lg0, rp0};
    assign v1 = {lvl1, pr1, rl1, lg1, rp1};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [24:0] obs,
                         input logic [24:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h (lvl|prs|rel|lng|rep)",
                   tag, obs, exp);
        end
    endtask

    // Tick c=1 is the edge that first samples the new input into s1.
    function automatic logic [24:0] exp_vec(input logic [4:0] m,
        input int c, input int hold, input bit ren);
        int p;
        int r;
        logic lv, pr, rl, lg, rp;
        p  = 6;
        r  = hold + 6;
        lv = (c >= p) && (c < r);
        pr = (c == p);
        rl = (c == r);
        lg = (c == p + 16) && (c < r);
        rp = ren && (c > p + 16) && (c < r)
          && (((c - p - 16) % 8) == 0);
        return {{5{lv}} & m, {5{pr}} & m, {5{rl}} & m,
                {5{lg}} & m, {5{rp}} & m};
    endfunction

    task automatic run_hold(input string tag, input logic [4:0] m,
        input int hold, input int total, input bit sel);
        if (sel) BTN_IN2 = BTN_IN2 | m;
        else     BTN_IN  = BTN_IN | m;
        for (int c = 1; c <= total; c++) begin
            tick();
            if (sel) check($sformatf("%s@%0d", tag, c), v1,
                           exp_vec(m, c, hold, 1'b0));
            else     check($sformatf("%s@%0d", tag, c), v0,
                           exp_vec(m, c, hold, 1'b1));
            if (c == hold) begin
                if (sel) BTN_IN2 = BTN_IN2 & ~m;
                else     BTN_IN  = BTN_IN & ~m;
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("reset_dut", v0, '0);
        check("reset_norep", v1, '0);
        RST = 1'b0;
        tick();
        check("idle_dut", v0, '0);

        run_hold("ch3_basic", 5'b01000, 20, 35, 1'b0);

        // 3 high, 2 low, 3 high: never persists 4 cycles at s2
        for (int c = 0; c < 20; c++) begin
            BTN_IN[1] = (c < 3) || (c >= 5 && c < 8);
            tick();
            check($sformatf("bounce@%0d", c), v0, '0);
        end

        run_hold("ch0_long", 5'b00001, 35, 50, 1'b0);
        run_hold("ch04_simul", 5'b10001, 20, 30, 1'b0);

        BTN_IN[2] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("ch2_prerst@%0d", c), v0,
                  exp_vec(5'b00100, c, 1000, 1'b1));
        end
        RST = 1'b1;
        tick();
        check("ch2_rst1", v0, '0);
        tick();
        check("ch2_rst2", v0, '0);
        RST = 1'b0;
        run_hold("ch2_postrst", 5'b00100, 20, 30, 1'b0);

        run_hold("norep_ch1", 5'b00010, 40, 50, 1'b1);
        check("norep_dut_idle", v0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
